input_debouncer: RTL and testbench

//  Conditions a raw asynchronous input (switch/button) before it reaches the inverter stage.
//  Two-flop synchronizer, then a stability counter/FSM; x_db changes only after STABLE_CYCLES agreeing samples.
//  x_db drives the inverter input x directly. rise/fall give single-cycle edge strobes to downstream logic.

---
 rtl/input_debouncer.sv | 126 ++++++++++++
 tb/tb_input_debouncer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// Debounces a raw asynchronous level for the inverter stage.
// Two-flop synchronizer plus a stability FSM with edge strobes.
module input_debouncer #(
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 5,
  parameter bit RESET_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic x_raw,
  output logic x_db,
  output logic rise,
  output logic fall,
  output logic busy
);

  typedef enum logic [1:0] {
    ST_STABLE_LO,
    ST_WAIT_HI,
    ST_STABLE_HI,
    ST_WAIT_LO
  } state_t;

  localparam logic [CNT_W-1:0] C_LAST =
    CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  logic           r_s1;
  logic           r_s2;
  logic           r_x_db;
  logic           r_rise;
  logic           r_fall;
  logic           r_busy;
  logic [CNT_W-1:0] r_cnt;
  state_t         r_state;

  // Bring x_raw into the clk domain; only r_s2 is consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1 <= RESET_LEVEL;
      r_s2 <= RESET_LEVEL;
    end else begin
      r_s1 <= x_raw;
      r_s2 <= r_s1;
    end
  end

  // Qualify level changes; accept after STABLE_CYCLES agreeing samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x_db  <= RESET_LEVEL;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_busy  <= 1'b0;
      r_state <= RESET_LEVEL ? ST_STABLE_HI
                             : ST_STABLE_LO;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      unique case (r_state)
        ST_STABLE_LO: begin
          if (r_s2) begin
            r_state <= ST_WAIT_HI;
            r_cnt   <= C_ONE;
            r_busy  <= 1'b1;
          end else begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
          end
        end
        ST_WAIT_HI: begin
          if (!r_s2) begin
            r_state <= ST_STABLE_LO;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == C_LAST) begin
            r_state <= ST_STABLE_HI;
            r_x_db  <= 1'b1;
            r_rise  <= 1'b1;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        ST_STABLE_HI: begin
          if (!r_s2) begin
            r_state <= ST_WAIT_LO;
            r_cnt   <= C_ONE;
            r_busy  <= 1'b1;
          end else begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
          end
        end
        ST_WAIT_LO: begin
          if (r_s2) begin
            r_state <= ST_STABLE_HI;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == C_LAST) begin
            r_state <= ST_STABLE_LO;
            r_x_db  <= 1'b0;
            r_fall  <= 1'b1;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        default: begin
          r_state <= ST_STABLE_LO;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign x_db = r_x_db;
  assign rise = r_rise;
  assign fall = r_fall;
  assign busy = r_busy;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed and randomized checks for input_debouncer.
// STABLE_CYCLES=4, RESET_LEVEL=0.
module tb_input_debouncer;

  logic clk = 1'b0;
  logic rst_n;
  logic x_raw;
  logic x_db;
  logic rise;
  logic fall;
  logic busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  input_debouncer #(
    .STABLE_CYCLES(4),
    .CNT_W(3),
    .RESET_LEVEL(1'b0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .x_raw(x_raw),
    .x_db(x_db),
    .rise(rise),
    .fall(fall),
    .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    x_raw = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      x_raw = ~x_raw;
      tick();
      checks++;
      if ({x_db, rise, fall, busy} !== 4'b0000) begin
        errors++;
        $display("FAIL reset k=%0d got db/r/f/b=%b want 0000",
                 k, {x_db, rise, fall, busy});
      end
    end
    x_raw = 1'b0;
    tick();
    rst_n = 1'b1;
    // Input already at reset level: nothing happens.
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if ({x_db, rise, fall, busy} !== 4'b0000) begin
        errors++;
        $display("FAIL rel_same k=%0d got %b want 0000",
                 k, {x_db, rise, fall, busy});
      end
    end
  endtask

  // First sampling edge is k=1; acceptance lands on k=6.
  task automatic test_rise();
    x_raw = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      checks++;
      if (x_db !== (k >= 6) || rise !== (k == 6) ||
          fall !== 1'b0 || busy !== (k >= 3 && k <= 5)) begin
        errors++;
        $display("FAIL rise k=%0d got db/r/f/b=%b%b%b%b want %b%b0%b",
                 k, x_db, rise, fall, busy,
                 k >= 6, k == 6, k >= 3 && k <= 5);
      end
    end
  endtask

  task automatic test_fall();
    x_raw = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      checks++;
      if (x_db !== (k < 6) || fall !== (k == 6) ||
          rise !== 1'b0 || busy !== (k >= 3 && k <= 5)) begin
        errors++;
        $display("FAIL fall k=%0d got db/r/f/b=%b%b%b%b want %b0%b%b",
                 k, x_db, rise, fall, busy,
                 k < 6, k == 6, k >= 3 && k <= 5);
      end
    end
  endtask

  // Three high samples reach cnt=3 then abort on the fourth look.
  task automatic test_glitch();
    for (int k = 1; k <= 10; k++) begin
      x_raw = (k <= 3);
      tick();
      checks++;
      if (x_db !== 1'b0 || rise !== 1'b0 || fall !== 1'b0 ||
          busy !== (k >= 3 && k <= 5)) begin
        errors++;
        $display("FAIL glitch k=%0d got db/r/f/b=%b%b%b%b want 000%b",
                 k, x_db, rise, fall, busy, k >= 3 && k <= 5);
      end
    end
  endtask

  task automatic test_toggle();
    for (int k = 1; k <= 24; k++) begin
      x_raw = k[0];
      tick();
      checks++;
      if (x_db !== 1'b0 || rise !== 1'b0 || fall !== 1'b0) begin
        errors++;
        $display("FAIL toggle k=%0d got db/r/f=%b%b%b want 000",
                 k, x_db, rise, fall);
      end
    end
    x_raw = 1'b0;
    repeat (4) tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL toggle_idle got busy=%b want 0", busy);
    end
  endtask

  // Reset on the second edge spent in WAIT_HI.
  task automatic test_reset_mid();
    x_raw = 1'b1;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy got %b want 1", busy);
    end
    rst_n = 1'b0;
    x_raw = 1'b0;
    tick();
    checks++;
    if ({x_db, rise, fall, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL mid_rst got %b want 0000",
               {x_db, rise, fall, busy});
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if ({x_db, rise, fall, busy} !== 4'b0000) begin
        errors++;
        $display("FAIL mid_after k=%0d got %b want 0000",
                 k, {x_db, rise, fall, busy});
      end
    end
  endtask

  // Input high while reset releases: one normal rise.
  task automatic test_release_high();
    int n_rise;
    n_rise = 0;
    rst_n = 1'b0;
    x_raw = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (rise === 1'b1) n_rise++;
      checks++;
      if (rise !== (k == 6) || x_db !== (k >= 6)) begin
        errors++;
        $display("FAIL rel_hi k=%0d got db/r=%b%b want %b%b",
                 k, x_db, rise, k >= 6, k == 6);
      end
    end
    checks++;
    if (n_rise != 1) begin
      errors++;
      $display("FAIL rel_hi_count got %0d want 1", n_rise);
    end
  endtask

  // Reference: run-length of synchronized samples differing
  // from the accepted level; four in a row flips it.
  task automatic test_random();
    bit m_s1, m_s2, m_db, m_rise, m_fall, m_busy;
    int m_run, cyc, len;
    bit lvl;
    rst_n = 1'b0;
    x_raw = 1'b0;
    tick();
    rst_n = 1'b1;
    m_s1 = 0; m_s2 = 0; m_db = 0; m_run = 0;
    lvl = 1'b0;
    cyc = 0;
    while (cyc < 10000) begin
      lvl = ~lvl;
      len = $urandom_range(1, 10);
      for (int j = 0; j < len; j++) begin
        x_raw = lvl;
        @(posedge clk);
        m_rise = 0;
        m_fall = 0;
        if (m_s2 != m_db) begin
          m_run++;
          if (m_run == 4) begin
            m_db = m_s2;
            m_run = 0;
            m_rise = m_db;
            m_fall = !m_db;
          end
        end else begin
          m_run = 0;
        end
        m_busy = (m_run != 0);
        m_s2 = m_s1;
        m_s1 = x_raw;
        #1;
        cyc++;
        checks++;
        if (x_db !== m_db || rise !== m_rise ||
            fall !== m_fall || busy !== m_busy ||
            (rise & fall) !== 1'b0) begin
          errors++;
          $display("FAIL rand cyc=%0d got db/r/f/b=%b%b%b%b want %b%b%b%b",
                   cyc, x_db, rise, fall, busy,
                   m_db, m_rise, m_fall, m_busy);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    x_raw = 1'b0;
    test_reset();
    test_rise();
    test_fall();
    test_glitch();
    test_toggle();
    test_reset_mid();
    test_release_high();
    test_fall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
